// File: rtl/rca_arbiter_if.sv
// Bundle of the rca_arbiter requester, adder and response signals.
// Optional macro RCA_ARBITER_OVF_EN adds the rsp_ovf signed-overflow flag.
// slave  : the arbiter side.
// master : the environment side (requesters, shared adder, response sink).
interface rca_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;

    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
`ifdef RCA_ARBITER_OVF_EN
    logic                  rsp_ovf;
`endif
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
`ifdef RCA_ARBITER_OVF_EN
        output rsp_ovf,
`endif
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum,
               rsp_cout, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
`ifdef RCA_ARBITER_OVF_EN
        input  rsp_ovf,
`endif
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum,
               rsp_cout, busy
    );
endinterface

// File: rtl/rca_arbiter.sv
// Round-robin arbiter sharing one multicycle ripple-carry adder among NREQ
// requesters. One operation at a time: IDLE grants and captures operands,
// EXEC holds them on the adder for LATENCY cycles, RESP presents the
// captured result until the response handshake completes.
// Optional macro RCA_ARBITER_OVF_EN adds the registered rsp_ovf output.
module rca_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int LATENCY = WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    rca_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   rr_next;
    logic              gnt_any;
    logic              accept;
    logic [NREQ-1:0]   gnt_vec;
    int                idx;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              op_cin;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              rsp_valid_q;
    logic              busy_q;
`ifdef RCA_ARBITER_OVF_EN
    logic              ovf_q;
    logic              ovf_now;
`endif

    // Search upward from rr_ptr (with wrap) for the first valid requester.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    // A grant is only offered in IDLE and never while reset is applied.
    assign accept  = (state == IDLE) && !rst && gnt_any;
    assign rr_next = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // One-hot ready toward the single granted requester.
    always_comb begin
        gnt_vec = '0;
        if (accept) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

`ifdef RCA_ARBITER_OVF_EN
    // Signed overflow: like-signed operands giving an opposite-signed sum.
    assign ovf_now = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                     (bus.add_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif

    // Arbitration FSM with operand capture, execution timer and result capture.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            cnt         <= '0;
            id_q        <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RCA_ARBITER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= bus.req_a[gnt_idx*WIDTH +: WIDTH];
                        op_b   <= bus.req_b[gnt_idx*WIDTH +: WIDTH];
                        op_cin <= bus.req_cin[gnt_idx];
                        id_q   <= gnt_idx;
                        rr_ptr <= rr_next;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for LATENCY cycles when the
                    // counter reaches its last value; sample the adder then.
                    if (cnt == CNT_W'(LATENCY - 1)) begin
                        sum_q       <= bus.add_sum;
                        cout_q      <= bus.add_cout;
`ifdef RCA_ARBITER_OVF_EN
                        ovf_q       <= ovf_now;
`endif
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = gnt_vec;
    assign bus.add_a     = op_a;
    assign bus.add_b     = op_b;
    assign bus.add_cin   = op_cin;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.busy      = busy_q;
`ifdef RCA_ARBITER_OVF_EN
    assign bus.rsp_ovf   = ovf_q;
`endif

endmodule
